// File: rtl/rv32_data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_data_memory_responder_if
// Description : Load/store bus between the core (master) and the data-memory
//               responder (slave): read request/response, store request and
//               the shared fault strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_data_memory_responder_if;
    logic        memory_read_request;
    logic [31:0] memory_read_address;
    logic [1:0]  memory_read_size;
    logic        memory_read_unsigned;
    logic [31:0] memory_read_value;
    logic        memory_read_valid;
    logic        memory_busy;
    logic        memory_write_request;
    logic [31:0] memory_write_address;
    logic [1:0]  memory_write_size;
    logic [31:0] memory_write_value;
    logic        memory_fault;

    modport master (
        output memory_read_request,
        output memory_read_address,
        output memory_read_size,
        output memory_read_unsigned,
        input  memory_read_value,
        input  memory_read_valid,
        input  memory_busy,
        output memory_write_request,
        output memory_write_address,
        output memory_write_size,
        output memory_write_value,
        input  memory_fault
    );

    modport slave (
        input  memory_read_request,
        input  memory_read_address,
        input  memory_read_size,
        input  memory_read_unsigned,
        output memory_read_value,
        output memory_read_valid,
        output memory_busy,
        input  memory_write_request,
        input  memory_write_address,
        input  memory_write_size,
        input  memory_write_value,
        output memory_fault
    );
endinterface
`default_nettype wire

// File: rtl/rv32_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv32_data_memory_responder
// Description : Data-memory responder for the RV32 core. Loads return
//               extended data a fixed READ_LATENCY edges after acceptance;
//               stores commit byte/half/word lanes at the accepting edge.
//               Misaligned, out-of-range and reserved-size accesses raise a
//               one-cycle fault strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_data_memory_responder #(
    parameter int          ADDRESS_WIDTH = 10,
    parameter int          READ_LATENCY  = 2,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    rv32_data_memory_responder_if.slave  bus
);

    localparam int          c_depth      = 1 << ADDRESS_WIDTH;
    // Span in bytes held in 33 bits so a 2^30-word array still fits.
    localparam logic [32:0] c_span_bytes = 33'd1 << (ADDRESS_WIDTH + 2);

    localparam logic [1:0] c_state_idle    = 2'd0;
    localparam logic [1:0] c_state_wait    = 2'd1;
    localparam logic [1:0] c_state_respond = 2'd2;

    // WAIT lasts READ_LATENCY-1 cycles; the counter is loaded with the
    // number of extra WAIT cycles after the first one.
    localparam logic [2:0] c_wait_load    = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;
    // A single-cycle latency skips WAIT entirely.
    localparam logic [1:0] c_accept_state = (READ_LATENCY == 1) ? c_state_respond : c_state_wait;

    // Fault rule shared by loads and stores. The 33-bit difference wraps
    // above 2^32 when the address lies below the base, so one compare
    // covers both ends of the range.
    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] distance;
        logic        misaligned;
        distance   = {1'b0, addr} - {1'b0, BASE_ADDRESS};
        misaligned = (size == 2'd3)
                  || ((size == 2'd1) && addr[0])
                  || ((size == 2'd2) && (addr[1:0] != 2'b00));
        return misaligned || (distance >= c_span_bytes);
    endfunction

    logic [31:0]              r_mem [c_depth];

    logic [1:0]               r_state;
    logic [2:0]               r_count;
    logic [31:0]              r_pending_value;
    logic                     r_pending_fault;
    logic [31:0]              r_read_value;
    logic                     r_read_valid;
    logic                     r_fault;

    logic                     w_read_fault;
    logic [ADDRESS_WIDTH-1:0] w_read_index;
    logic [31:0]              w_read_word;
    logic [7:0]               w_read_byte;
    logic [15:0]              w_read_half;
    logic [31:0]              w_read_data;
    logic                     w_read_accept;
    logic                     w_responding;

    logic                     w_write_fault;
    logic [ADDRESS_WIDTH-1:0] w_write_index;
    logic [3:0]               w_write_strobe;
    logic [31:0]              w_write_data;

    // Load path: fetch the addressed word and extract/extend the lane.
    always_comb begin
        w_read_fault = access_fault(bus.memory_read_address, bus.memory_read_size);
        w_read_index = ADDRESS_WIDTH'((bus.memory_read_address - BASE_ADDRESS) >> 2);
        w_read_word  = r_mem[w_read_index];
        case (bus.memory_read_address[1:0])
            2'd0:    w_read_byte = w_read_word[7:0];
            2'd1:    w_read_byte = w_read_word[15:8];
            2'd2:    w_read_byte = w_read_word[23:16];
            default: w_read_byte = w_read_word[31:24];
        endcase
        w_read_half = bus.memory_read_address[1] ? w_read_word[31:16] : w_read_word[15:0];
        case (bus.memory_read_size)
            2'd0: begin
                w_read_data = bus.memory_read_unsigned ? {24'd0, w_read_byte}
                                                       : {{24{w_read_byte[7]}}, w_read_byte};
            end
            2'd1: begin
                w_read_data = bus.memory_read_unsigned ? {16'd0, w_read_half}
                                                       : {{16{w_read_half[15]}}, w_read_half};
            end
            default: w_read_data = w_read_word;
        endcase
        // A faulting load still completes, but carries no data.
        if (w_read_fault) begin
            w_read_data = 32'd0;
        end
    end

    // Store path: lane strobes and lane-replicated data for the store size.
    always_comb begin
        w_write_fault = access_fault(bus.memory_write_address, bus.memory_write_size);
        w_write_index = ADDRESS_WIDTH'((bus.memory_write_address - BASE_ADDRESS) >> 2);
        case (bus.memory_write_size)
            2'd0: begin
                w_write_strobe = 4'b0001 << bus.memory_write_address[1:0];
                w_write_data   = {4{bus.memory_write_value[7:0]}};
            end
            2'd1: begin
                w_write_strobe = bus.memory_write_address[1] ? 4'b1100 : 4'b0011;
                w_write_data   = {2{bus.memory_write_value[15:0]}};
            end
            default: begin
                w_write_strobe = 4'b1111;
                w_write_data   = bus.memory_write_value;
            end
        endcase
    end

    assign w_read_accept = bus.memory_read_request && (r_state != c_state_wait);
    assign w_responding  = (r_state == c_state_respond);

    // Commit non-faulting stores lane by lane; the array itself has no reset.
    always_ff @(posedge clock) begin
        if (!reset && enable && bus.memory_write_request && !w_write_fault) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (w_write_strobe[lane]) begin
                    r_mem[w_write_index][lane*8 +: 8] <= w_write_data[lane*8 +: 8];
                end
            end
        end
    end

    // Read sequencing, response registers and the merged fault strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= c_state_idle;
            r_count         <= 3'd0;
            r_pending_value <= 32'd0;
            r_pending_fault <= 1'b0;
            r_read_value    <= 32'd0;
            r_read_valid    <= 1'b0;
            r_fault         <= 1'b0;
        end else if (enable) begin
            r_read_valid <= w_responding;
            r_read_value <= w_responding ? r_pending_value : 32'd0;
            // Read and write faults landing together collapse into one pulse.
            r_fault      <= (w_responding && r_pending_fault)
                         || (bus.memory_write_request && w_write_fault);

            if (w_read_accept) begin
                r_pending_value <= w_read_data;
                r_pending_fault <= w_read_fault;
            end

            case (r_state)
                c_state_idle: begin
                    if (w_read_accept) begin
                        r_state <= c_accept_state;
                        r_count <= c_wait_load;
                    end
                end
                c_state_wait: begin
                    if (r_count == 3'd0) begin
                        r_state <= c_state_respond;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                c_state_respond: begin
                    if (w_read_accept) begin
                        r_state <= c_accept_state;
                        r_count <= c_wait_load;
                    end else begin
                        r_state <= c_state_idle;
                    end
                end
                default: begin
                    r_state <= c_state_idle;
                    r_count <= 3'd0;
                end
            endcase
        end
    end

    assign bus.memory_read_value = r_read_value;
    assign bus.memory_read_valid = r_read_valid;
    assign bus.memory_busy       = (r_state == c_state_wait);
    assign bus.memory_fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_rv32_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_data_memory_responder
// Description : Self-checking bench for rv32_data_memory_responder: directed
//               load/store scenarios followed by randomized traffic, checked
//               against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_data_memory_responder;

    localparam int          AW          = 10;
    localparam int          LAT         = 2;
    localparam logic [31:0] BASE        = 32'h0000_0000;
    localparam int          DEPTH_BYTES = 4 << AW;

    logic clock = 1'b0;
    logic reset;
    logic enable;

    always #5 clock = ~clock;

    rv32_data_memory_responder_if bus ();

    rv32_data_memory_responder #(
        .ADDRESS_WIDTH (AW),
        .READ_LATENCY  (LAT),
        .BASE_ADDRESS  (BASE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] model_mem [DEPTH_BYTES];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference fault rule: alignment by size, then byte offset inside the array.
    function automatic logic model_fault(input logic [31:0] a, input logic [1:0] sz);
        longint off;
        logic   bad_align;
        off = longint'(a) - longint'(BASE);
        case (sz)
            2'd0:    bad_align = 1'b0;
            2'd1:    bad_align = (a % 2) != 0;
            2'd2:    bad_align = (a % 4) != 0;
            default: bad_align = 1'b1;
        endcase
        return bad_align || (off < 0) || (off >= DEPTH_BYTES);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int          off;
        logic [31:0] v;
        if (model_fault(a, sz)) return 32'd0;
        off = int'(a - BASE);
        case (sz)
            2'd0: begin
                v = 32'(model_mem[off]);
                if (!uns && v >= 32'd128) v = v - 32'd256;
            end
            2'd1: begin
                v = 32'(model_mem[off]) + 32'd256 * 32'(model_mem[off+1]);
                if (!uns && v >= 32'd32768) v = v - 32'd65536;
            end
            default: begin
                v = 32'(model_mem[off]) + 32'd256 * 32'(model_mem[off+1])
                  + 32'd65536 * 32'(model_mem[off+2]) + 32'd16777216 * 32'(model_mem[off+3]);
            end
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int off;
        if (model_fault(a, sz)) return;
        off = int'(a - BASE);
        for (int i = 0; i < (1 << sz); i++) model_mem[off+i] = d[8*i +: 8];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d, input string tag);
        logic exp_f;
        exp_f = model_fault(a, sz);
        bus.memory_write_request = 1'b1;
        bus.memory_write_address = a;
        bus.memory_write_size    = sz;
        bus.memory_write_value   = d;
        step();
        bus.memory_write_request = 1'b0;
        check({tag, "_wfault"}, 32'(bus.memory_fault), 32'(exp_f));
        model_write(a, sz, d);
    endtask

    // Issue one load (optionally with a same-edge store), optionally stall
    // enable for some cycles, then wait a bounded time for the response.
    task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                           input int stall, input logic wr_en, input logic [31:0] wa,
                           input logic [1:0] ws, input logic [31:0] wd, input string tag);
        logic [31:0] exp_v;
        logic        exp_f;
        logic        exp_wf;
        int          got;
        exp_v  = model_read(a, sz, uns);
        exp_f  = model_fault(a, sz);
        exp_wf = model_fault(wa, ws);
        check({tag, "_idle_busy"}, 32'(bus.memory_busy), 32'd0);
        bus.memory_read_request  = 1'b1;
        bus.memory_read_address  = a;
        bus.memory_read_size     = sz;
        bus.memory_read_unsigned = uns;
        bus.memory_write_request = wr_en;
        bus.memory_write_address = wa;
        bus.memory_write_size    = ws;
        bus.memory_write_value   = wd;
        step();
        bus.memory_read_request  = 1'b0;
        bus.memory_write_request = 1'b0;
        check({tag, "_busy"}, 32'(bus.memory_busy), 32'd1);
        if (wr_en) begin
            model_write(wa, ws, wd);
            check({tag, "_wfault"}, 32'(bus.memory_fault), 32'(exp_wf));
        end
        got = 0;
        for (int k = 1; k <= 16; k++) begin
            enable = (k > stall);
            step();
            if (bus.memory_read_valid) begin
                got = k;
                break;
            end
        end
        enable = 1'b1;
        check({tag, "_latency"}, 32'(got), 32'(LAT + stall));
        check({tag, "_value"}, bus.memory_read_value, exp_v);
        check({tag, "_rfault"}, 32'(bus.memory_fault), 32'(exp_f));
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        int          r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, 255));
        if (r == 0) return 32'h0000_1000 + 32'($urandom_range(0, 4095));
        if (r <= 2 || sz == 2'd3) return a;
        return a & ~((32'd1 << sz) - 32'd1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [1:0]  sz;
        logic [1:0]  wsz;
        int          kind;

        reset                    = 1'b1;
        enable                   = 1'b1;
        bus.memory_read_request  = 1'b0;
        bus.memory_read_address  = 32'd0;
        bus.memory_read_size     = 2'd0;
        bus.memory_read_unsigned = 1'b0;
        bus.memory_write_request = 1'b0;
        bus.memory_write_address = 32'd0;
        bus.memory_write_size    = 2'd0;
        bus.memory_write_value   = 32'd0;
        step();
        step();
        check("reset_valid", 32'(bus.memory_read_valid), 32'd0);
        check("reset_busy",  32'(bus.memory_busy),       32'd0);
        check("reset_fault", 32'(bus.memory_fault),      32'd0);
        check("reset_value", bus.memory_read_value,      32'd0);
        reset = 1'b0;
        step();

        // Word store then load.
        do_write(32'h10, 2'd2, 32'hDEAD_BEEF, "sw_10");
        do_read (32'h10, 2'd2, 1'b0, 0, 1'b0, 0, 0, 0, "lw_10");
        check("lw_10_const", bus.memory_read_value, 32'hDEAD_BEEF);

        // Byte store, then sub-word loads with both extensions.
        do_write(32'h13, 2'd0, 32'h0000_0080, "sb_13");
        do_read (32'h13, 2'd0, 1'b0, 0, 1'b0, 0, 0, 0, "lb_13");
        do_read (32'h13, 2'd0, 1'b1, 0, 1'b0, 0, 0, 0, "lbu_13");
        do_read (32'h10, 2'd2, 1'b0, 0, 1'b0, 0, 0, 0, "lw_10b");
        check("lw_10b_const", bus.memory_read_value, 32'h80AD_BEEF);
        do_read (32'h12, 2'd1, 1'b0, 0, 1'b0, 0, 0, 0, "lh_12");
        check("lh_12_const", bus.memory_read_value, 32'hFFFF_80AD);

        // Fault cases.
        do_read (32'h11, 2'd1, 1'b0, 0, 1'b0, 0, 0, 0, "lh_11_misaligned");
        do_write(32'h12, 2'd2, 32'h1234_5678, "sw_12_misaligned");
        do_read (32'h10, 2'd2, 1'b0, 0, 1'b0, 0, 0, 0, "lw_10_after_fault");
        do_read (BASE + 32'h1000, 2'd2, 1'b0, 0, 1'b0, 0, 0, 0, "lw_out_of_range");
        do_read (32'h10, 2'd3, 1'b0, 0, 1'b0, 0, 0, 0, "reserved_size");

        // Same-edge read and write to one word: read returns old data.
        do_read (32'h10, 2'd2, 1'b0, 0, 1'b1, 32'h10, 2'd2, 32'h1111_1111, "lw_sw_same_edge");
        check("lw_sw_same_edge_const", bus.memory_read_value, 32'h80AD_BEEF);
        do_read (32'h10, 2'd2, 1'b0, 0, 1'b0, 0, 0, 0, "lw_after_same_edge");
        check("lw_after_same_edge_const", bus.memory_read_value, 32'h1111_1111);

        // Reset while a read is pending: the read is never answered.
        bus.memory_read_request = 1'b1;
        bus.memory_read_address = 32'h10;
        bus.memory_read_size    = 2'd2;
        step();
        bus.memory_read_request = 1'b0;
        check("rst_wait_busy_before", 32'(bus.memory_busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_busy_after",  32'(bus.memory_busy),       32'd0);
        check("rst_wait_valid_after", 32'(bus.memory_read_valid), 32'd0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.memory_read_valid) seen++;
        end
        check("rst_wait_no_response", 32'(seen), 32'd0);
        do_read (32'h10, 2'd2, 1'b0, 0, 1'b0, 0, 0, 0, "lw_after_reset");

        // Enable dropped for three cycles while waiting.
        do_read (32'h10, 2'd2, 1'b0, 3, 1'b0, 0, 0, 0, "lw_stalled");
        check("lw_stalled_const", bus.memory_read_value, 32'h1111_1111);

        // Randomized phase: fill the first 256 bytes, then mixed traffic.
        for (int w = 0; w < 64; w++) begin
            do_write(32'(w * 4), 2'd2, $urandom, "init");
        end
        for (int n = 0; n < 80; n++) begin
            sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wsz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 2));
            case (kind)
                0:       do_write(rand_addr(wsz), wsz, $urandom, "rnd_w");
                1:       do_read (rand_addr(sz), sz, 1'($urandom_range(0, 1)), 0, 1'b0, 0, 0, 0, "rnd_r");
                default: do_read (rand_addr(sz), sz, 1'($urandom_range(0, 1)),
                                  int'($urandom_range(0, 2)), 1'b1, rand_addr(wsz), wsz, $urandom, "rnd_rw");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
